// File: rtl/weight_loader.sv
// Collects the weight stream into an n_pe x k_size kernel set and commits it to a double-buffered output bank.
// Optional WEIGHT_LOADER_CHECKSUM_EN adds k_sum, the unsigned sum of the committed set.
module weight_loader #(
    parameter int data_width = 16,
    parameter int k_size     = 9,
    parameter int n_pe       = 4
) (
    input  logic                              clk,
    input  logic                              nrst,
    input  logic                              start,
    input  logic                              clr,
    input  logic [data_width-1:0]             w_in,
    input  logic                              w_vld,
    output logic                              w_rd,
    output logic [n_pe*k_size*data_width-1:0] k_out,
    output logic                              k_vld,
    input  logic                              k_ack,
    output logic                              busy,
    output logic                              done,
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    output logic [data_width+7:0]             k_sum,
`endif
    output logic                              ovf
);

    localparam int N  = n_pe * k_size;
    localparam int CW = $clog2(N + 1);
    localparam int SW = data_width + 8;

    typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;

    state_t                   state;
    logic [CW-1:0]            count;
    logic [N*data_width-1:0]  fill;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    logic [SW-1:0]            acc;
`endif

    always_comb begin
        w_rd = (state == LOAD);
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
            count <= '0;
            fill  <= '0;
            k_out <= '0;
            k_vld <= 1'b0;
            done  <= 1'b0;
            ovf   <= 1'b0;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
            acc   <= '0;
            k_sum <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (clr) begin
                state <= IDLE;
                count <= '0;
                k_vld <= 1'b0;
                ovf   <= 1'b0;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
                acc   <= '0;
                k_sum <= '0;
`endif
            end else begin
                // A commit in WAIT below overrides this ack-driven clear.
                if (k_ack && k_vld)
                    k_vld <= 1'b0;
                case (state)
                    IDLE: begin
                        if (w_vld)
                            ovf <= 1'b1;
                        if (start) begin
                            state <= LOAD;
                            count <= '0;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
                            acc   <= '0;
`endif
                        end
                    end
                    LOAD: begin
                        if (w_vld) begin
                            fill[count*data_width +: data_width] <= w_in;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
                            acc <= acc + SW'(w_in);
`endif
                            if (count == CW'(N - 1)) begin
                                state <= WAIT;
                                count <= '0;
                            end else begin
                                count <= count + 1'b1;
                            end
                        end
                    end
                    WAIT: begin
                        if (w_vld)
                            ovf <= 1'b1;
                        if (!k_vld || k_ack) begin
                            k_out <= fill;
                            k_vld <= 1'b1;
                            done  <= 1'b1;
                            state <= IDLE;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
                            k_sum <= acc;
`endif
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_weight_loader.sv
// Directed/randomized bench for weight_loader; the model tracks the committed bank as an array of weights.
module tb_weight_loader;

    localparam int DW = 16;
    localparam int K  = 9;
    localparam int P  = 4;
    localparam int N  = K * P;

    logic          clk = 1'b0;
    logic          nrst;
    logic          start;
    logic          clr;
    logic [DW-1:0] w_in;
    logic          w_vld;
    logic          w_rd;
    logic [N*DW-1:0] k_out;
    logic          k_vld;
    logic          k_ack;
    logic          busy;
    logic          done;
    logic          ovf;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    logic [DW+7:0] k_sum;
`endif

    weight_loader #(.data_width(DW), .k_size(K), .n_pe(P)) dut (
        .clk(clk), .nrst(nrst), .start(start), .clr(clr),
        .w_in(w_in), .w_vld(w_vld), .w_rd(w_rd),
        .k_out(k_out), .k_vld(k_vld), .k_ack(k_ack),
        .busy(busy), .done(done),
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        .k_sum(k_sum),
`endif
        .ovf(ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] w[N];
    logic [DW-1:0] exp_bank[N];
    logic [23:0]   exp_sum;
    int            load_cyc;
    int            gap_tot;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_bank(input string tag);
        logic [N*DW-1:0] ev;
        int bad;
        bad = 0;
        for (int i = 0; i < N; i++) begin
            ev[i*DW +: DW] = exp_bank[i];
            if (bad == 0 && k_out[i*DW +: DW] !== exp_bank[i]) bad = i;
        end
        checks++;
        assert (k_out === ev) else begin
            errors++;
            $error("FAIL %s element %0d observed=%0h expected=%0h",
                   tag, bad, k_out[bad*DW +: DW], exp_bank[bad]);
        end
    endtask

    // mode 0: continuous, 1: one gap between weights, 2: random 0..2 gaps before each weight
    task automatic feed_set(input int mode, input string tag);
        int g;
        start = 1'b1;
        step();
        start = 1'b0;
        chk({tag, "_w_rd_first"}, 64'(w_rd), 64'(1));
        load_cyc = 0;
        gap_tot  = 0;
        for (int i = 0; i < N; i++) begin
            g = (mode == 1) ? ((i > 0) ? 1 : 0) : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
            gap_tot += g;
            for (int j = 0; j < g; j++) begin
                w_vld = 1'b0;
                step();
                load_cyc++;
            end
            w_vld = 1'b1;
            w_in  = w[i];
            step();
            load_cyc++;
        end
        w_vld = 1'b0;
        chk({tag, "_load_len"}, 64'(load_cyc), 64'(N + gap_tot));
        chk({tag, "_w_rd_wait"}, 64'(w_rd), 64'(0));
        chk({tag, "_busy_wait"}, 64'(busy), 64'(1));
    endtask

    task automatic commit_expect(input string tag);
        logic [23:0] s;
        s = '0;
        for (int i = 0; i < N; i++) begin
            exp_bank[i] = w[i];
            s += 24'(w[i]);
        end
        exp_sum = s;
        step();
        chk({tag, "_k_vld"}, 64'(k_vld), 64'(1));
        chk({tag, "_done"}, 64'(done), 64'(1));
        chk({tag, "_busy_idle"}, 64'(busy), 64'(0));
        chk_bank({tag, "_k_out"});
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        chk({tag, "_k_sum"}, 64'(k_sum), 64'(exp_sum));
`endif
    endtask

    task automatic after_commit(input string tag);
        k_ack = 1'b0;
        step();
        chk({tag, "_done_fall"}, 64'(done), 64'(0));
        chk({tag, "_k_vld_hold"}, 64'(k_vld), 64'(1));
    endtask

    task automatic ack_clear(input string tag);
        k_ack = 1'b1;
        step();
        k_ack = 1'b0;
        chk({tag, "_ack_clear"}, 64'(k_vld), 64'(0));
        chk({tag, "_ack_nodone"}, 64'(done), 64'(0));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_k_vld"}, 64'(k_vld), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_ovf"}, 64'(ovf), 64'(0));
        chk({tag, "_w_rd"}, 64'(w_rd), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk_bank({tag, "_k_out"});
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        chk({tag, "_k_sum"}, 64'(k_sum), 64'(0));
`endif
    endtask

    initial begin
        nrst = 1'b0; start = 1'b0; clr = 1'b0;
        w_in = '0; w_vld = 1'b0; k_ack = 1'b0;
        for (int i = 0; i < N; i++) exp_bank[i] = '0;
        #2;
        chk_all_zero("reset");
        step(); step();
        nrst = 1'b1;
        step();

        // continuous stream 1..36
        for (int i = 0; i < N; i++) w[i] = DW'(i + 1);
        feed_set(0, "seq");
        commit_expect("seq");
        chk("seq_first_word", 64'(k_out[15:0]), 64'h0001);
        chk("seq_last_word", 64'(k_out[575:560]), 64'h0024);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        chk("seq_sum_666", 64'(k_sum), 64'h029A);
`endif
        after_commit("seq");
        ack_clear("seq");

        // alternate-cycle stream, same data
        feed_set(1, "gap");
        chk("gap_load_71", 64'(load_cyc), 64'(71));
        commit_expect("gap");
        chk("gap_ovf", 64'(ovf), 64'(0));
        after_commit("gap");
        ack_clear("gap");

        // double buffering: A committed, B parks in WAIT until ack
        for (int i = 0; i < N; i++) w[i] = 16'h00AA;
        feed_set(0, "setA");
        commit_expect("setA");
        after_commit("setA");
        for (int i = 0; i < N; i++) w[i] = 16'h00BB;
        feed_set(0, "setB");
        for (int c = 0; c < 3; c++) step();
        chk("park_busy", 64'(busy), 64'(1));
        chk("park_done", 64'(done), 64'(0));
        chk_bank("park_k_out_A");
        k_ack = 1'b1;
        commit_expect("setB");
        after_commit("setB");

        // misuse in IDLE while bank is valid, then clr
        w_vld = 1'b1; w_in = 16'h1234;
        step();
        w_vld = 1'b0;
        chk("misuse_ovf", 64'(ovf), 64'(1));
        chk("misuse_busy", 64'(busy), 64'(0));
        chk_bank("misuse_k_out");
        step();
        chk("misuse_ovf_sticky", 64'(ovf), 64'(1));
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_ovf", 64'(ovf), 64'(0));
        chk("clr_k_vld", 64'(k_vld), 64'(0));
        chk_bank("clr_k_out");

        // reset mid-load after 10 weights
        for (int i = 0; i < N; i++) w[i] = DW'($urandom);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            w_vld = 1'b1; w_in = w[i];
            step();
        end
        w_vld = 1'b0;
        chk("midload_busy", 64'(busy), 64'(1));
        nrst = 1'b0;
        #1;
        for (int i = 0; i < N; i++) exp_bank[i] = '0;
        chk_all_zero("midreset");
        step();
        nrst = 1'b1;
        step();
        feed_set(2, "post_rst");
        commit_expect("post_rst");
        after_commit("post_rst");

        // all-0xFFFF set with commit and ack in the same cycle
        for (int i = 0; i < N; i++) w[i] = 16'hFFFF;
        feed_set(0, "ones");
        step();
        chk("ones_parked", 64'(done), 64'(0));
        k_ack = 1'b1;
        commit_expect("ones");
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        chk("ones_sum", 64'(k_sum), 64'h23FFDC);
`endif
        after_commit("ones");

        // random sets with random gaps; commit against a valid bank via ack
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++) w[i] = DW'($urandom);
            feed_set(2, "rnd");
            k_ack = 1'b1;
            commit_expect("rnd");
            after_commit("rnd");
        end

        // w_vld in WAIT flags ovf; clr aborts the parked set
        for (int i = 0; i < N; i++) w[i] = DW'($urandom);
        feed_set(0, "wovf");
        w_vld = 1'b1; w_in = 16'h5555;
        step();
        w_vld = 1'b0;
        chk("wait_ovf", 64'(ovf), 64'(1));
        chk("wait_busy", 64'(busy), 64'(1));
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_wait_busy", 64'(busy), 64'(0));
        chk("clr_wait_ovf", 64'(ovf), 64'(0));
        chk("clr_wait_k_vld", 64'(k_vld), 64'(0));
        chk_bank("clr_wait_k_out");
        step();
        chk("clr_wait_no_done", 64'(done), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
